imm_encoder: RTL and testbench

Inverse of the immediate generator in the decode stage. It takes a 32-bit immediate value, an immediate-format select, and a base instruction word. It scatters the immediate into the format's instruction bit positions and flags values the format cannot represent. Optionally it expands a load-immediate pseudo-op into a one- or two-instruction LUI/ADDI sequence. It sits in the test-program generator / boot-ROM builder path and feeds instruction words to memory through a valid/ready stream.

---
 rtl/imm_encoder.sv | 187 ++++++++++++++++++
 tb/tb_imm_encoder.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: scatters an immediate into RV32 instruction fields and flags unrepresentable values.
// Define IMM_ENC_LI_EN to compile in the load-immediate (LUI/ADDI) expansion and its LUI state.
module imm_encoder (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [2:0]  i_ImmSel,
  input  logic [31:0] i_Imm,
  input  logic [31:0] i_Base,
  input  logic        i_li,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_Instr,
  output logic        o_Last,
  output logic        o_RangeErr
);

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

`ifdef IMM_ENC_LI_EN
  typedef enum logic [1:0] {S_IDLE, S_BEAT, S_LUI} state_e;
`else
  typedef enum logic {S_IDLE, S_BEAT} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        last_q, last_d;
  logic        err_q, err_d;

  logic        accept;
  logic        out_hs;
  logic        fits_s12, fits_s13, fits_s21;
  logic [31:0] pack_word;
  logic        pack_err;

`ifdef IMM_ENC_LI_EN
  logic [11:0] lo_q, lo_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  li_rd;
  logic [19:0] li_hi;
  logic [31:0] li_first;
  logic        li_two;
  logic [31:0] li_addi;
`else
  logic        unused_li;
  assign unused_li = i_li;
`endif

  assign o_out_valid = (state_q != S_IDLE);
  assign o_Instr     = instr_q;
  assign o_Last      = last_q;
  assign o_RangeErr  = err_q;

  assign o_in_ready = !i_rst & ((state_q == S_IDLE) | ((state_q == S_BEAT) & i_out_ready));
  assign accept     = i_in_valid & o_in_ready;
  assign out_hs     = o_out_valid & i_out_ready;

  assign fits_s12 = (&i_Imm[31:11]) | ~(|i_Imm[31:11]);
  assign fits_s13 = (&i_Imm[31:12]) | ~(|i_Imm[31:12]);
  assign fits_s21 = (&i_Imm[31:20]) | ~(|i_Imm[31:20]);

  always_comb begin
    pack_word = i_Base;
    pack_err  = 1'b0;
    case (i_ImmSel)
      3'b000: begin
        pack_word[31:20] = i_Imm[11:0];
        pack_err         = !fits_s12;
      end
      3'b001: begin
        pack_word[31:20] = i_Imm[11:0];
        pack_err         = |i_Imm[31:12];
      end
      3'b010: begin
        pack_word[31:25] = i_Imm[11:5];
        pack_word[11:7]  = i_Imm[4:0];
        pack_err         = !fits_s12;
      end
      3'b011: begin
        pack_word[31]    = i_Imm[12];
        pack_word[30:25] = i_Imm[10:5];
        pack_word[11:8]  = i_Imm[4:1];
        pack_word[7]     = i_Imm[11];
        pack_err         = i_Imm[0] | !fits_s13;
      end
      3'b100: begin
        pack_word[31:12] = i_Imm[31:12];
        pack_err         = |i_Imm[11:0];
      end
      3'b101: begin
        pack_word[31]    = i_Imm[20];
        pack_word[30:21] = i_Imm[10:1];
        pack_word[20]    = i_Imm[11];
        pack_word[19:12] = i_Imm[19:12];
        pack_err         = i_Imm[0] | !fits_s21;
      end
      default: ;
    endcase
  end

`ifdef IMM_ENC_LI_EN
  // (imm + 0x800) >> 12 only carries into bit 12 when imm[11] is set.
  assign li_rd   = i_Base[11:7];
  assign li_hi   = i_Imm[31:12] + {19'd0, i_Imm[11]};
  assign li_addi = {lo_q, rd_q, 3'b000, rd_q, OP_IMM};

  always_comb begin
    li_first = {i_Imm[11:0], 5'd0, 3'b000, li_rd, OP_IMM};
    li_two   = 1'b0;
    if (!fits_s12) begin
      li_first = {li_hi, li_rd, OP_LUI};
      li_two   = |i_Imm[11:0];
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    last_d  = last_q;
    err_d   = err_q;
`ifdef IMM_ENC_LI_EN
    lo_d    = lo_q;
    rd_d    = rd_q;
`endif
    case (state_q)
      S_BEAT: if (out_hs) state_d = S_IDLE;
`ifdef IMM_ENC_LI_EN
      S_LUI: begin
        if (out_hs) begin
          state_d = S_BEAT;
          instr_d = li_addi;
          last_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
`endif
      default: ;
    endcase

    // Accept is only possible from IDLE or a completing BEAT, so it overrides the above.
    if (accept) begin
      state_d = S_BEAT;
      instr_d = pack_word;
      last_d  = 1'b1;
      err_d   = pack_err;
`ifdef IMM_ENC_LI_EN
      if (i_li) begin
        instr_d = li_first;
        err_d   = 1'b0;
        lo_d    = i_Imm[11:0];
        rd_d    = li_rd;
        if (li_two) begin
          state_d = S_LUI;
          last_d  = 1'b0;
        end
      end
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef IMM_ENC_LI_EN
      lo_q    <= '0;
      rd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      last_q  <= last_d;
      err_q   <= err_d;
`ifdef IMM_ENC_LI_EN
      lo_q    <= lo_d;
      rd_q    <= rd_d;
`endif
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic [2:0]  i_ImmSel = '0;
  logic [31:0] i_Imm = '0;
  logic [31:0] i_Base = '0;
  logic        i_li = 1'b0;
  logic        o_out_valid;
  logic        i_out_ready = 1'b1;
  logic [31:0] o_Instr;
  logic        o_Last;
  logic        o_RangeErr;

  always #5 clk = ~clk;

  imm_encoder dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_ImmSel    (i_ImmSel),
    .i_Imm       (i_Imm),
    .i_Base      (i_Base),
    .i_li        (i_li),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_Instr     (o_Instr),
    .o_Last      (o_Last),
    .o_RangeErr  (o_RangeErr)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic        last;
    logic        err;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  bit          rdy_rand = 1'b0;
  bit          rdy_force = 1'b1;
  int unsigned stall_total = 0;
  logic [31:0] bnd [10] = '{32'h000007FF, 32'h00000800, 32'hFFFFF800, 32'hFFFFF7FF, 32'h00000FFF,
                            32'h00001000, 32'h00000FFE, 32'hFFFFF000, 32'h000FFFFE, 32'hFFF00000};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
  endtask

  // Reference model: per-bit source table, range by signed arithmetic.
  function automatic logic [31:0] scatter(input logic [2:0] sel, input logic [31:0] imm,
                                          input logic [31:0] base);
    logic [31:0] w;
    int src;
    w = base;
    for (int b = 0; b < 32; b++) begin
      src = -1;
      case (sel)
        3'd0, 3'd1: if (b >= 20) src = b - 20;
        3'd2: if (b >= 25) src = b - 20; else if (b >= 7 && b <= 11) src = b - 7;
        3'd3: if (b == 31) src = 12; else if (b >= 25) src = b - 20;
              else if (b >= 8 && b <= 11) src = b - 7; else if (b == 7) src = 11;
        3'd4: if (b >= 12) src = b;
        3'd5: if (b == 31) src = 20; else if (b >= 21) src = b - 20;
              else if (b == 20) src = 11; else if (b >= 12) src = b;
        default: ;
      endcase
      if (src >= 0) w[b] = imm[src];
    end
    return w;
  endfunction

  function automatic logic range_err(input logic [2:0] sel, input logic [31:0] imm);
    int s;
    s = $signed(imm);
    case (sel)
      3'd0, 3'd2: return !(s >= -2048 && s < 2048);
      3'd1:       return imm >= 32'd4096;
      3'd3:       return imm[0] || !(s >= -4096 && s < 4096);
      3'd4:       return (imm % 32'd4096) != 0;
      3'd5:       return imm[0] || !(s >= -(1 << 20) && s < (1 << 20));
      default:    return 1'b0;
    endcase
  endfunction

  function automatic int li_beats(input logic [31:0] imm, input logic [4:0] rd,
                                  output logic [31:0] w0, output logic [31:0] w1);
    int s;
    logic [31:0] hi, lo, rdw;
    s   = $signed(imm);
    rdw = 32'(rd);
    w1  = '0;
    if (s >= -2048 && s < 2048) begin
      w0 = ((imm & 32'hFFF) << 20) | (rdw << 7) | 32'h13;
      return 1;
    end
    hi = (imm + 32'h800) >> 12;
    lo = imm & 32'hFFF;
    w0 = (hi << 12) | (rdw << 7) | 32'h37;
    if (lo == 0) return 1;
    w1 = (lo << 20) | (rdw << 15) | (rdw << 7) | 32'h13;
    return 2;
  endfunction

  task automatic push_beat(input logic [31:0] instr, input logic last, input logic err);
    beat_t b;
    b.instr = instr;
    b.last  = last;
    b.err   = err;
    exp_q.push_back(b);
  endtask

  task automatic push_model(input logic li, input logic [2:0] sel, input logic [31:0] imm,
                            input logic [31:0] base);
`ifdef IMM_ENC_LI_EN
    logic [31:0] w0, w1;
    int n;
    if (li) begin
      n = li_beats(imm, base[11:7], w0, w1);
      if (n == 1) push_beat(w0, 1'b1, 1'b0);
      else begin
        push_beat(w0, 1'b0, 1'b0);
        push_beat(w1, 1'b1, 1'b0);
      end
      return;
    end
`endif
    push_beat(scatter(sel, imm, base), 1'b1, range_err(sel, imm));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge with i_in_valid still high.
  task automatic send(input logic li, input logic [2:0] sel, input logic [31:0] imm,
                      input logic [31:0] base, input bit manual, output int unsigned waited);
    waited     = 0;
    i_in_valid = 1'b1;
    i_li       = li;
    i_ImmSel   = sel;
    i_Imm      = imm;
    i_Base     = base;
    forever begin
      @(negedge clk);
      #2;
      if (o_in_ready) begin
        if (!manual) push_model(li, sel, imm, base);
        break;
      end
      if (waited >= 60) begin
        n_chk++;
        $display("FAIL accept_timeout: waited %0d cycles, required < 60", waited);
        i_in_valid = 1'b0;
        break;
      end
      waited++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #2;
    i_out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  // Monitor: expected valid is "scoreboard non-empty"; ready follows the front beat's kind.
  beat_t mon_f;
  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready_in_reset", {31'd0, o_in_ready}, 32'd0);
      exp_q.delete();
    end else if (exp_q.size() != 0) begin
      mon_f = exp_q[0];
      chk("out_valid", {31'd0, o_out_valid}, 32'd1);
      chk("in_ready", {31'd0, o_in_ready}, {31'd0, mon_f.last & i_out_ready});
      if (o_out_valid) begin
        chk("instr", o_Instr, mon_f.instr);
        chk("last", {31'd0, o_Last}, {31'd0, mon_f.last});
        chk("range_err", {31'd0, o_RangeErr}, {31'd0, mon_f.err});
        if (i_out_ready) void'(exp_q.pop_front());
      end
    end else begin
      chk("out_valid_idle", {31'd0, o_out_valid}, 32'd0);
      chk("in_ready_idle", {31'd0, o_in_ready}, 32'd1);
    end
  end

  initial begin
    int unsigned w;
    logic [2:0]  sel;
    logic [31:0] imm;
    logic        li;

    step();
    step();
    @(negedge clk);
    #1;
    chk("rst_out_valid", {31'd0, o_out_valid}, 32'd0);
    chk("rst_instr", o_Instr, 32'd0);
    chk("rst_last", {31'd0, o_Last}, 32'd0);
    chk("rst_err", {31'd0, o_RangeErr}, 32'd0);
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    #1;
    chk("post_rst_in_ready", {31'd0, o_in_ready}, 32'd1);
    step();

    // Directed format vectors with expected words written out.
    send(1'b0, 3'b000, 32'hFFFFF800, 32'h00000013, 1'b1, w);
    push_beat(32'h80000013, 1'b1, 1'b0);
    send(1'b0, 3'b011, 32'h00000FFE, 32'h00000063, 1'b1, w);
    push_beat(32'h7E000FE3, 1'b1, 1'b0);
    send(1'b0, 3'b011, 32'h00000003, 32'h00000063, 1'b1, w);
    push_beat(32'h00000163, 1'b1, 1'b1);
    send(1'b0, 3'b110, 32'h12345678, 32'hDEADBEEF, 1'b1, w);
    push_beat(32'hDEADBEEF, 1'b1, 1'b0);
    send(1'b0, 3'b100, 32'hABCDE001, 32'h00000037, 1'b1, w);
    push_beat(32'hABCDE037, 1'b1, 1'b1);
    send(1'b0, 3'b001, 32'h00000FFF, 32'h00000013, 1'b1, w);
    push_beat(32'hFFF00013, 1'b1, 1'b0);

    // Back-to-back single-beat requests under continuous ready.
    for (int k = 0; k < 4; k++) begin
      send(1'b0, 3'b010, 32'(k * 3), 32'h00000023, 1'b0, w);
      chk("throughput_wait", w, 32'd0);
    end

`ifdef IMM_ENC_LI_EN
    send(1'b1, 3'b111, 32'h00001000, 32'hFFFFF2FF, 1'b1, w);
    push_beat(32'h000012B7, 1'b1, 1'b0);
    send(1'b1, 3'b010, 32'hFFFFFFFF, 32'hFFFFF2FF, 1'b1, w);
    push_beat(32'hFFF00293, 1'b1, 1'b0);
    i_in_valid = 1'b0;
    step();
    step();

    // Backpressure on beat 1, then a new request accepted on the beat-2 handshake.
    rdy_force = 1'b0;
    send(1'b1, 3'b000, 32'h12345FFF, 32'hFFFFF2FF, 1'b1, w);
    push_beat(32'h123462B7, 1'b0, 1'b0);
    push_beat(32'hFFF28293, 1'b1, 1'b0);
    i_in_valid = 1'b0;
    step();
    step();
    step();
    rdy_force = 1'b1;
    step();
    send(1'b0, 3'b000, 32'h00000005, 32'h00000013, 1'b1, w);
    push_beat(32'h00500013, 1'b1, 1'b0);
    chk("accept_on_beat2", w, 32'd0);
    i_in_valid = 1'b0;
    step();
    step();

    // Reset while the LUI beat is pending.
    rdy_force = 1'b0;
    send(1'b1, 3'b000, 32'h12345FFF, 32'hFFFFF2FF, 1'b1, w);
    push_beat(32'h123462B7, 1'b0, 1'b0);
    push_beat(32'hFFF28293, 1'b1, 1'b0);
    i_in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rdy_force = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_mid_li_valid", {31'd0, o_out_valid}, 32'd0);
    chk("rst_mid_li_ready", {31'd0, o_in_ready}, 32'd1);
    step();
    step();
    step();
`else
    send(1'b1, 3'b000, 32'h12345FFF, 32'h00000293, 1'b1, w);
    push_beat(32'hFFF00293, 1'b1, 1'b1);
    i_in_valid = 1'b0;
    step();
    step();
`endif

    rdy_rand = 1'b1;
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) begin
        i_in_valid = 1'b0;
        step();
      end else begin
        li  = ($urandom_range(0, 3) == 0);
        sel = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 5))
          0: imm = $urandom;
          1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
          2: imm = $urandom & 32'hFFFFF000;
          3: imm = ($urandom & 32'h001FFFFE) - 32'h00100000;
          4: imm = bnd[$urandom_range(0, 9)];
          default: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        endcase
        send(li, sel, imm, $urandom, 1'b0, w);
        stall_total += w;
      end
    end

    rdy_rand   = 1'b0;
    rdy_force  = 1'b1;
    i_in_valid = 1'b0;
    begin
      int unsigned t = 0;
      while (exp_q.size() != 0 && t < 100) begin
        step();
        t++;
      end
      if (exp_q.size() != 0) begin
        n_chk++;
        $display("FAIL drain: %0d beats still expected after %0d cycles, required 0", exp_q.size(), t);
      end
    end
    step();
    step();
    $display("random phase accept stalls: %0d cycles", stall_total);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
